// File: rtl/sign_mag_pkg.sv
// Shared definitions for the sign/magnitude to BCD converter.
package sign_mag_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int unsigned BCD_W = 4;

  // Smallest digit count whose decimal range covers every bits-wide magnitude.
  function automatic int unsigned min_digits(input int unsigned bits);
    longint unsigned max_val;
    longint unsigned pow10;
    int unsigned     d;
    max_val = (64'd1 << bits) - 64'd1;
    pow10   = 64'd10;
    d       = 1;
    while (pow10 <= max_val) begin
      pow10 = pow10 * 64'd10;
      d     = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble add-3 correction for a single BCD digit.
module bcd_digit_adjust
  import sign_mag_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adjusted_c
);

  assign adjusted_c = (digit >= BCD_W'(5)) ? digit + BCD_W'(3) : digit;

endmodule

// File: rtl/sign_mag_to_bcd.sv
// Iterative double-dabble converter: one magnitude bit per clock, start/busy/done handshake.
module sign_mag_to_bcd
  import sign_mag_pkg::*;
#(
  parameter int unsigned BITS   = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    sign,
  input  logic [BITS-1:0]         value,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    neg,
  output logic [DIGITS-1:0]       blank
);

  localparam int unsigned BCD_TOTAL = BCD_W * DIGITS;
  localparam int unsigned CNT_W     = $clog2(BITS + 1);

  generate
    if (DIGITS < min_digits(BITS)) begin : g_bad_digits
      $error("sign_mag_to_bcd: DIGITS too small for BITS");
    end
  endgenerate

  logic [1:0]           state_q, state_d;
  logic [BITS-1:0]      bin_q, bin_d;
  logic [BCD_TOTAL-1:0] scr_q, scr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sign_q, sign_d;
  logic                 nz_q, nz_d;
  logic                 busy_d, done_d, neg_d;
  logic [BCD_TOTAL-1:0] bcd_d;
  logic [DIGITS-1:0]    blank_d;

  logic [BCD_TOTAL-1:0] adj;
  logic [BCD_TOTAL-1:0] scr_shift;
  logic [DIGITS-1:0]    blank_next;
  logic                 zero_above;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit      (scr_q[g*BCD_W +: BCD_W]),
      .adjusted_c (adj[g*BCD_W +: BCD_W])
    );
  end

  assign scr_shift = {adj[BCD_TOTAL-2:0], bin_q[BITS-1]};

  // A digit is blanked only when it and every more-significant digit are zero.
  always_comb begin
    blank_next = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (scr_shift[i*BCD_W +: BCD_W] == '0);
      blank_next[i] = zero_above;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    nz_d    = nz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    bcd_d   = bcd;
    neg_d   = neg;
    blank_d = blank;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d   = value;
          scr_d   = '0;
          sign_d  = sign;
          nz_d    = (value != '0);
          cnt_d   = CNT_W'(BITS);
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scr_d = scr_shift;
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Final shift: results land in the output registers as DONE is entered.
          state_d = ST_DONE;
          done_d  = 1'b1;
          bcd_d   = scr_shift;
          neg_d   = sign_q & nz_q;
          blank_d = blank_next;
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      nz_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      neg     <= 1'b0;
      blank   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      nz_q    <= nz_d;
      busy    <= busy_d;
      done    <= done_d;
      bcd     <= bcd_d;
      neg     <= neg_d;
      blank   <= blank_d;
    end
  end

endmodule

// File: tb/tb_sign_mag_to_bcd.sv
// Self-checking bench for sign_mag_to_bcd: decimal-arithmetic model plus directed vectors.
module tb_sign_mag_to_bcd;

  localparam int unsigned BITS   = 8;
  localparam int unsigned DIGITS = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [7:0]  value = 8'd0;
  logic        busy, done, neg;
  logic [11:0] bcd;
  logic [2:0]  blank;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sign_mag_to_bcd #(.BITS(BITS), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sign  (sign),
    .value (value),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .neg   (neg),
    .blank (blank)
  );

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] blank_of(input int v);
    return {v < 100, v < 10, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: a conversion occupies BITS shift cycles, then one done cycle.
  int          m_left = 0;
  int          m_val = 0;
  logic        m_sign = 1'b0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_neg = 1'b0;
  logic [11:0] m_bcd = '0;
  logic [2:0]  m_blank = '0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_left = 0; m_busy = 1'b0; m_done = 1'b0;
      m_bcd = '0; m_neg = 1'b0; m_blank = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_busy  = 1'b0;
        m_done  = 1'b1;
        m_bcd   = to_bcd(m_val);
        m_neg   = m_sign && (m_val != 0);
        m_blank = blank_of(m_val);
      end
    end else if (start) begin
      m_val  = int'(value);
      m_sign = sign;
      m_left = BITS;
      m_busy = 1'b1;
    end
  end

  int done_cnt = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("busy",  32'(busy),  32'(m_busy));
      check("done",  32'(done),  32'(m_done));
      check("bcd",   32'(bcd),   32'(m_bcd));
      check("neg",   32'(neg),   32'(m_neg));
      check("blank", 32'(blank), 32'(m_blank));
      if (done === 1'b1) done_cnt++;
    end
  end

  int acc_cyc = 0;
  int busy_cnt = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic launch(input logic s, input int v);
    @(negedge clk);
    start = 1'b1; sign = s; value = 8'(v);
    @(negedge clk);
    start = 1'b0; sign = 1'($urandom); value = 8'($urandom);
    acc_cyc  = cyc;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
    end
    check("done_timeout", 32'(ok), 32'd1);
  endtask

  int d0, t1, t2;

  initial begin
    tick(3);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_bcd",   32'(bcd),   32'd0);
    check("rst_blank", 32'(blank), 32'd0);
    rst_n = 1'b1;

    // 255: busy 8 cycles, done BITS edges after the accepting edge
    launch(1'b0, 255);
    wait_done();
    check("lat_255",   32'(cyc - acc_cyc), 32'd8);
    check("busy_len",  32'(busy_cnt), 32'd8);
    check("bcd_255",   32'(bcd), 32'h255);
    check("model_255", 32'(m_bcd), 32'h255);
    check("neg_255",   32'(neg), 32'd0);
    check("blank_255", 32'(blank), 32'b000);

    launch(1'b1, 128);
    wait_done();
    check("bcd_128", 32'(bcd), 32'h128);
    check("neg_128", 32'(neg), 32'd1);
    check("blank_128", 32'(blank), 32'b000);

    launch(1'b1, 7);
    wait_done();
    check("bcd_7",   32'(bcd), 32'h007);
    check("neg_7",   32'(neg), 32'd1);
    check("blank_7", 32'(blank), 32'b110);
    check("model_blank_7", 32'(m_blank), 32'b110);

    // negative zero
    launch(1'b1, 0);
    wait_done();
    check("bcd_nz",   32'(bcd), 32'h000);
    check("neg_nz",   32'(neg), 32'd0);
    check("blank_nz", 32'(blank), 32'b110);
    tick(1);
    check("done_width", 32'(done), 32'd0);

    // start during SHIFT is ignored
    d0 = done_cnt;
    launch(1'b0, 42);
    tick(2);
    start = 1'b1; value = 8'd99;
    tick(1);
    start = 1'b0;
    wait_done();
    check("bcd_42", 32'(bcd), 32'h042);
    tick(12);
    check("one_done", 32'(done_cnt - d0), 32'd1);
    check("bcd_42_hold", 32'(bcd), 32'h042);

    // reset mid-conversion
    launch(1'b1, 200);
    tick(3);
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_busy",  32'(busy),  32'd0);
    check("mid_rst_bcd",   32'(bcd),   32'd0);
    check("mid_rst_neg",   32'(neg),   32'd0);
    check("mid_rst_blank", 32'(blank), 32'd0);
    rst_n = 1'b1;
    d0 = done_cnt;
    tick(12);
    check("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    launch(1'b0, 9);
    wait_done();
    check("bcd_9", 32'(bcd), 32'h009);

    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1; sign = 1'b0; value = 8'd10;
    @(negedge clk);
    value = 8'd250;
    wait_done();
    t1 = cyc;
    check("bcd_10", 32'(bcd), 32'h010);
    tick(2);
    start = 1'b0;
    wait_done();
    t2 = cyc;
    check("bcd_250", 32'(bcd), 32'h250);
    check("b2b_spacing", 32'(t2 - t1), 32'd10);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
